rf_wr_arbiter: RTL
==================

Name: rf_wr_arbiter

Overview:
- Sequences the single write port of the 16-entry register file and shares it between N writeback requesters (ALU result, memory load, link/PC writeback).
- Picks one requester round-robin, latches its target address and data, then drives the one-hot write decoder:
  - we feeds the decoder's enable input.
  - waddr[3:0] feeds its select inputs, waddr[3] is the MSB select.
- Acknowledges the requester after the write completes.
- Sits between the multicycle control unit and the register file.

Parameters:
- N, 3, number of requesters (2..8).
- AW, 4, register address width (decoder select width).
- DW, 16, write data width.
- R0_PROTECT, 1, when 1 writes to address 0 are acknowledged but not performed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  per-requester write request, level, held until gnt.
- addr  input  N*AW  per-requester target register; requester i occupies bits [i*AW +: AW].
- data  input  N*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
- gnt  output  N  one-hot, one-cycle write-complete acknowledge.
- we  output  1  register-file write enable, drives the decoder enable.
- waddr  output  AW  latched write address, drives the decoder selects.
- wdata  output  DW  latched write data to the register file.
- busy  output  1  high in any state other than IDLE.
- dropped  output  1  one-cycle pulse when a protected address-0 write is suppressed.

Behaviour:
- Everything is synchronous to the rising edge of clk. All outputs are registered.
- Reset (rst_n=0 at an edge) produces:
  - state=IDLE, ptr=0.
  - we=0, gnt=0, busy=0, dropped=0.
  - waddr=0, wdata=0, internal winner=0.
- Reset mid-operation aborts the transaction: no we, no gnt. The requester keeps req high and is re-arbitrated after reset.
- IDLE:
  - If req != 0, select the winner by searching indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first index with req set wins.
  - Latch the winner's addr and data into waddr/wdata, go to WRITE, set busy=1.
  - If req == 0, stay in IDLE; waddr/wdata hold their last values.
- WRITE (exactly one cycle):
  - we=1, unless R0_PROTECT=1 and waddr==0. In that case we=0 and dropped=1 for this cycle.
  - waddr/wdata are stable for the whole cycle.
  - Next state is ACK.
- ACK (exactly one cycle):
  - we=0, gnt[winner]=1, all other gnt bits 0.
  - ptr <= winner+1, wrapping N-1 -> 0.
  - Next state is IDLE, busy=0.
- Latency and throughput:
  - The req edge is sampled in IDLE. we is high 1 cycle after that sample; gnt is high 2 cycles after it.
  - Maximum throughput is one write per 3 cycles.
- Requester rule:
  - The requester deasserts req at the edge where it samples gnt=1.
  - req still high in the IDLE cycle after ACK is treated as a new request.
- Inputs are ignored in WRITE and ACK: changes to addr, data or req do not affect the transaction in flight.
- Fairness: a continuously requesting requester waits at most N-1 other transactions.
- Simultaneous requests: only one winner per arbitration. The losers keep req high and compete at the next IDLE.
- Invariants:
  - we and any gnt bit are never high in the same cycle.
  - gnt is always one-hot or zero.

Test Plan:
- Reset, then req=3'b010, addr1=4'h5, data1=16'hBEEF.
  - IDLE sample at cycle 0 gives we=1 with waddr=5, wdata=BEEF at cycle 1.
  - gnt=3'b010 at cycle 2; busy high for cycles 1-2; ptr becomes 2.
- Round-robin with all three req held continuously from reset:
  - Grant order is 0,1,2,0,1,2.
  - gnt pulses 3 cycles apart; no we/gnt overlap.
- R0_PROTECT=1, req0 with addr0=0, data0=16'h1234: we stays 0, dropped=1 in the WRITE cycle, gnt=3'b001 in the next cycle.
- Input change during transaction:
  - Requester 2 wins with addr=4'hA, data=16'h0F0F.
  - Flip addr2 to 4'h3 and data2 to 16'hFFFF in the WRITE cycle.
  - Required: waddr=A and wdata=0F0F throughout WRITE.
- Reset mid-WRITE:
  - Assert rst_n=0 in the WRITE cycle.
  - Next cycle: we=0, gnt=0, busy=0, ptr=0.
  - With req still held, the same requester is re-granted after reset releases.
- Wrap case: ptr=2 with req=3'b011 gives winner 0, then ptr=1.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// ============================================================================
//  Module      : rf_wr_arbiter
//  Description : Round-robin write-port sequencer for the 16-entry register
//                file; latches one requester's address/data, writes, then acks.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rf_wr_arbiter #(
    parameter int N          = 3,
    parameter int AW         = 4,
    parameter int DW         = 16,
    parameter int R0_PROTECT = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    gnt_o,
    output logic            we_o,
    output logic [AW-1:0]   waddr_o,
    output logic [DW-1:0]   wdata_o,
    output logic            busy_o,
    output logic            dropped_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(2 * N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner_q;
    logic [PW-1:0]   winner_d;
    logic [N-1:0]    gnt_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;
    logic            busy_q;
    logic            dropped_q;

    logic [2*N-1:0]  w_req_dbl;
    logic [IW-1:0]   w_sum;
    logic            w_found;
    logic            w_suppress;
    logic [PW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_addr [N];
    logic [DW-1:0]   w_data [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_addr[g] = addr_i[g*AW +: AW];
        assign w_data[g] = data_i[g*DW +: DW];
    end

    // Doubling the request vector turns the circular search from ptr into a linear one.
    assign w_req_dbl = {req_i, req_i};

    always_comb begin
        winner_d = ptr_q;
        w_sum    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_sum = IW'(ptr_q) + IW'(i);
            if (!w_found && w_req_dbl[w_sum]) begin
                w_found  = 1'b1;
                winner_d = (w_sum >= IW'(N)) ? PW'(w_sum - IW'(N)) : PW'(w_sum);
            end
        end
    end

    assign w_suppress = (R0_PROTECT != 0) && (w_addr[winner_d] == '0);
    assign w_ptr_next = (winner_q == PW'(N - 1)) ? '0 : winner_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            winner_q  <= '0;
            gnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gnt_q <= '0;
                    if (|req_i) begin
                        winner_q  <= winner_d;
                        waddr_q   <= w_addr[winner_d];
                        wdata_q   <= w_data[winner_d];
                        we_q      <= !w_suppress;
                        dropped_q <= w_suppress;
                        busy_q    <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_q      <= 1'b0;
                    dropped_q <= 1'b0;
                    gnt_q     <= N'(1) << winner_q;
                    ptr_q     <= w_ptr_next;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    gnt_q     <= '0;
                    we_q      <= 1'b0;
                    dropped_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign we_o      = we_q;
    assign waddr_o   = waddr_q;
    assign wdata_o   = wdata_q;
    assign busy_o    = busy_q;
    assign dropped_o = dropped_q;

endmodule

`default_nettype wire
